alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//  Upstream feeder for the 4-bit Alu (ports A, B, sel, res). Queues operation commands
//  arriving over a valid/ready channel, issues one command at a time to the Alu, captures
//  res into a result register and a running accumulator, and returns each result over a
//  valid/ready channel. Commands are processed strictly in arrival order (FIFO).
// PARAMETERS
//  WIDTH   4   operand/result width; must match Alu A/B/res width
//  DEPTH   4   command FIFO entries (power of 2, >=2)
//  MAX_OP  12  highest legal sel code; codes MAX_OP+1..15 are illegal
// PORTS
//  clk          in   1               rising-edge clock
//  rst          in   1               synchronous, active-high reset
//  cmd_valid    in   1               command present
//  cmd_ready    out  1               FIFO can accept (registered; = count<DEPTH && !rst-cycle)
//  cmd_op       in   4               Alu selector code
//  cmd_a        in   WIDTH           operand A (ignored when cmd_use_acc=1)
//  cmd_b        in   WIDTH           operand B
//  cmd_use_acc  in   1               1: operand A taken from acc at issue time
//  acc_clr      in   1               synchronous accumulator clear
//  alu_A        out  WIDTH           to Alu.A (registered)
//  alu_B        out  WIDTH           to Alu.B (registered)
//  alu_sel      out  4               to Alu.sel (registered)
//  alu_res      in   WIDTH           from Alu.res (combinational)
//  res_valid    out  1               result present
//  res_ready    in   1               consumer accepts result
//  res_data     out  WIDTH           captured result
//  res_err      out  1               1: command had illegal op
//  acc          out  WIDTH           accumulator
//  fifo_count   out  $clog2(DEPTH+1) queued (not yet popped) commands
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, FSM IDLE; in-flight command and queue discarded.
//    Applies from any state (mid-ISSUE/DONE): res_valid drops at the reset edge.
//  - Push on cmd_valid&&cmd_ready. No bypass: a pushed entry is poppable the following cycle.
//    Full FIFO: cmd_ready=0, no push. Push+pop same edge: count unchanged, pointers wrap mod DEPTH.
//  - FSM states IDLE, ISSUE, DONE:
//    IDLE : if fifo_count!=0 pop head; load alu_A = use_acc ? acc : a, alu_B = b, alu_sel = op
//           -> ISSUE. Illegal op: alu_A/alu_B/alu_sel loaded as 0, err flag latched.
//    ISSUE: one cycle for the Alu to settle; at its closing edge res_data <= alu_res
//           (0 if err), res_err <= err, res_valid <= 1, acc <= alu_res (unchanged if err) -> DONE.
//    DONE : hold res_* stable while res_ready=0; on res_valid&&res_ready, res_valid <= 0 -> IDLE.
//  - Latency: command accepted at edge t into empty FIFO with FSM IDLE -> ISSUE from t+1,
//    res_valid=1 from t+2. Max throughput one result per 3 cycles with res_ready held 1.
//  - alu_* retain last issued values outside ISSUE.
//  - Arithmetic: no width growth; res taken as WIDTH bits, wrap-around is the Alu's.
//  - acc_clr: acc <= 0; if coincident with an ISSUE capture edge, capture wins.
//  - use_acc reads acc at the IDLE->ISSUE edge (sees the previous command's result).
// TESTING (bench stub Alu: res = A+B mod 2^WIDTH for every legal sel; WIDTH=4, DEPTH=4)
//  1. Reset, push op=0 a=4 b=6 use_acc=0 -> ISSUE: alu_A=4 alu_B=6 alu_sel=0; res_valid 2 cycles
//     after accept, res_data=0xA, res_err=0, acc=0xA.
//  2. Then push op=3 b=7 use_acc=1 -> alu_A=0xA, res_data=0x1 (wrap), acc=0x1.
//  3. res_ready=0, cmd_valid held over 6 cmds -> exactly 5 accepted, fifo_count=4, cmd_ready=0;
//     release res_ready -> 5 results in push order, fifo_count returns to 0, cmd_ready=1.
//  4. Push op=13 a=5 b=5 -> alu_sel=0, alu_A=alu_B=0, res_err=1, res_data=0, acc unchanged.
//  5. Assert rst in DONE with 3 queued -> next edge res_valid=0, fifo_count=0, acc=0,
//     cmd_ready=0 while rst=1; new command after release runs normally (test 1 timing).
//  6. acc_clr on ISSUE capture edge -> acc = captured res; acc_clr while IDLE -> acc=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//   Feeds a combinational Alu from a small command FIFO. Commands are issued
//   one at a time in arrival order. Each result is captured into a result
//   register and a running accumulator, then returned over a valid/ready
//   channel.
//
// Ports
//   i_clk, i_rst        rising-edge clock, synchronous active-high reset
//   i_cmd_valid         command present
//   o_cmd_ready         FIFO can accept (registered)
//   i_cmd_op            Alu selector code
//   i_cmd_a, i_cmd_b    operands (a ignored when i_cmd_use_acc=1)
//   i_cmd_use_acc       take operand A from the accumulator at issue time
//   i_acc_clr           synchronous accumulator clear
//   o_alu_A/B/sel       registered drive to the Alu
//   i_alu_res           Alu result (combinational)
//   o_res_valid         result present
//   i_res_ready         consumer accepts result
//   o_res_data          captured result
//   o_res_err           command carried an illegal op
//   o_acc               accumulator
//   o_fifo_count        commands queued and not yet popped
//
// States
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | waiting for a queued command; pops and loads the Alu inputs
//   ST_ISSUE | Alu settling; result captured at the closing edge
//   ST_DONE  | result held on the output channel until accepted
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH  = 4,
    parameter int DEPTH  = 4,
    parameter int MAX_OP = 12
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_cmd_valid,
    output logic                         o_cmd_ready,
    input  logic [3:0]                   i_cmd_op,
    input  logic [WIDTH-1:0]             i_cmd_a,
    input  logic [WIDTH-1:0]             i_cmd_b,
    input  logic                         i_cmd_use_acc,
    input  logic                         i_acc_clr,
    output logic [WIDTH-1:0]             o_alu_A,
    output logic [WIDTH-1:0]             o_alu_B,
    output logic [3:0]                   o_alu_sel,
    input  logic [WIDTH-1:0]             i_alu_res,
    output logic                         o_res_valid,
    input  logic                         i_res_ready,
    output logic [WIDTH-1:0]             o_res_data,
    output logic                         o_res_err,
    output logic [WIDTH-1:0]             o_acc,
    output logic [$clog2(DEPTH+1)-1:0]   o_fifo_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [3:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             use_acc;
    } cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    // command FIFO
    cmd_t            r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            r_cmd_ready;

    // sequencer
    state_t          r_state;
    logic [WIDTH-1:0] r_alu_A;
    logic [WIDTH-1:0] r_alu_B;
    logic [3:0]      r_alu_sel;
    logic            r_err;
    logic            r_res_valid;
    logic [WIDTH-1:0] r_res_data;
    logic            r_res_err;
    logic [WIDTH-1:0] r_acc;

    logic            w_push;
    logic            w_pop;
    cmd_t            w_head;
    logic            w_head_illegal;
    logic [CW-1:0]   w_count_nxt;

    assign w_push         = i_cmd_valid && r_cmd_ready;
    assign w_pop          = (r_state == ST_IDLE) && (r_count != '0);
    assign w_head         = r_mem[r_rd_ptr];
    assign w_head_illegal = (w_head.op > 4'(MAX_OP));

    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CW'(1);
            2'b01:   w_count_nxt = r_count - CW'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // FIFO storage and pointers. Ready is registered from the next count so
    // it never asserts while the FIFO is full; pointers wrap naturally since
    // DEPTH is a power of two.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_cmd_ready <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= '{op: i_cmd_op, a: i_cmd_a, b: i_cmd_b,
                                     use_acc: i_cmd_use_acc};
                r_wr_ptr        <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count     <= w_count_nxt;
            r_cmd_ready <= (w_count_nxt < CW'(DEPTH));
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_alu_A     <= '0;
            r_alu_B     <= '0;
            r_alu_sel   <= '0;
            r_err       <= 1'b0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_err   <= 1'b0;
            r_acc       <= '0;
        end else begin
            // Clear applies in every state; the ISSUE capture below is a
            // later assignment and therefore takes priority.
            if (i_acc_clr) begin
                r_acc <= '0;
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        if (w_head_illegal) begin
                            r_alu_A   <= '0;
                            r_alu_B   <= '0;
                            r_alu_sel <= '0;
                            r_err     <= 1'b1;
                        end else begin
                            r_alu_A   <= w_head.use_acc ? r_acc : w_head.a;
                            r_alu_B   <= w_head.b;
                            r_alu_sel <= w_head.op;
                            r_err     <= 1'b0;
                        end
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_res_data  <= r_err ? '0 : i_alu_res;
                    r_res_err   <= r_err;
                    r_res_valid <= 1'b1;
                    if (!r_err) begin
                        r_acc <= i_alu_res;
                    end
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    if (i_res_ready) begin
                        r_res_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_cmd_ready  = r_cmd_ready;
    assign o_alu_A      = r_alu_A;
    assign o_alu_B      = r_alu_B;
    assign o_alu_sel    = r_alu_sel;
    assign o_res_valid  = r_res_valid;
    assign o_res_data   = r_res_data;
    assign o_res_err    = r_res_err;
    assign o_acc        = r_acc;
    assign o_fifo_count = r_count;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//   Drives alu_cmd_sequencer with a stub Alu (res = A + B mod 16). Expected
//   results are queued when a command is accepted and compared when the
//   result handshake happens.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [3:0]       cmd_op = '0;
    logic [WIDTH-1:0] cmd_a = '0;
    logic [WIDTH-1:0] cmd_b = '0;
    logic             cmd_use_acc = 1'b0;
    logic             acc_clr = 1'b0;
    logic [WIDTH-1:0] alu_A;
    logic [WIDTH-1:0] alu_B;
    logic [3:0]       alu_sel;
    logic [WIDTH-1:0] alu_res;
    logic             res_valid;
    logic             res_ready = 1'b1;
    logic [WIDTH-1:0] res_data;
    logic             res_err;
    logic [WIDTH-1:0] acc;
    logic [2:0]       fifo_count;

    always #5 clk = ~clk;

    assign alu_res = alu_A + alu_B;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_OP(12)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_cmd_valid   (cmd_valid),
        .o_cmd_ready   (cmd_ready),
        .i_cmd_op      (cmd_op),
        .i_cmd_a       (cmd_a),
        .i_cmd_b       (cmd_b),
        .i_cmd_use_acc (cmd_use_acc),
        .i_acc_clr     (acc_clr),
        .o_alu_A       (alu_A),
        .o_alu_B       (alu_B),
        .o_alu_sel     (alu_sel),
        .i_alu_res     (alu_res),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_res_data    (res_data),
        .o_res_err     (res_err),
        .o_acc         (acc),
        .o_fifo_count  (fifo_count)
    );

    typedef struct {
        logic [3:0] data;
        logic       err;
        logic [3:0] acc;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks  = 0;
    int         n_err     = 0;
    int         n_results = 0;
    logic [3:0] m_acc     = '0;

    task automatic check_eq(input string tag, input logic [31:0] act,
                            input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Model of one command, evaluated in acceptance order (which is also
    // issue order, so the model accumulator is the one the DUT will read).
    task automatic model_push(input logic [3:0] op, input logic [3:0] a,
                              input logic [3:0] b, input logic ua);
        exp_t       e;
        logic [3:0] r;
        if (op > 4'd12) begin
            e = '{data: 4'h0, err: 1'b1, acc: m_acc};
        end else begin
            r     = 4'((ua ? m_acc : a) + b);
            m_acc = r;
            e     = '{data: r, err: 1'b0, acc: r};
        end
        sb_q.push_back(e);
    endtask

    // Entered at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_cmd(input logic [3:0] op, input logic [3:0] a,
                            input logic [3:0] b, input logic ua,
                            input int budget, output bit accepted);
        cmd_op      = op;
        cmd_a       = a;
        cmd_b       = b;
        cmd_use_acc = ua;
        cmd_valid   = 1'b1;
        accepted    = 1'b0;
        for (int i = 0; i < budget && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                model_push(op, a, b, ua);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic push_ok(input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic ua);
        bit ok;
        push_cmd(op, a, b, ua, 20, ok);
        if (!ok) check_eq("push_timeout", 0, 1);
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (sb_q.size() == 0 && !res_valid && fifo_count == 3'd0)
                done = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) check_eq("drain_timeout", 0, 1);
    endtask

    // op=0 a=4 b=6 from an idle, empty sequencer with res_ready=1.
    task automatic run_basic(input string pfx);
        push_ok(4'd0, 4'd4, 4'd6, 1'b0);
        check_eq({pfx, "_cnt_t"},   32'(fifo_count), 1);
        check_eq({pfx, "_rv_t"},    32'(res_valid), 0);
        @(posedge clk); #1;
        check_eq({pfx, "_alu_A"},   32'(alu_A), 4);
        check_eq({pfx, "_alu_B"},   32'(alu_B), 6);
        check_eq({pfx, "_alu_sel"}, 32'(alu_sel), 0);
        check_eq({pfx, "_rv_t1"},   32'(res_valid), 0);
        check_eq({pfx, "_cnt_t1"},  32'(fifo_count), 0);
        @(posedge clk); #1;
        check_eq({pfx, "_rv_t2"},   32'(res_valid), 1);
        check_eq({pfx, "_data"},    32'(res_data), 32'hA);
        check_eq({pfx, "_err"},     32'(res_err), 0);
        check_eq({pfx, "_acc"},     32'(acc), 32'hA);
    endtask

    // Result monitor: a handshake seen mid-cycle completes on the next edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_result", 32'(res_data), 32'hFFFF);
                end else begin
                    e = sb_q.pop_front();
                    check_eq("res_data", 32'(res_data), 32'(e.data));
                    check_eq("res_err",  32'(res_err),  32'(e.err));
                    check_eq("res_acc",  32'(acc),      32'(e.acc));
                    n_results++;
                end
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_acc;
        int base;
        bit ok;
        logic [3:0] t_op [6] = '{4'd1, 4'd2, 4'd5, 4'd7, 4'd12, 4'd4};
        logic [3:0] t_a  [6] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
        logic [3:0] t_b  [6] = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        logic       t_ua [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_cmd_ready", 32'(cmd_ready), 0);
        check_eq("rst_count",     32'(fifo_count), 0);
        check_eq("rst_acc",       32'(acc), 0);
        check_eq("rst_alu_A",     32'(alu_A), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check_eq("post_rst_ready", 32'(cmd_ready), 1);

        // basic command and latency
        run_basic("t1");

        // use_acc with wrap-around
        push_ok(4'd3, 4'd0, 4'd7, 1'b1);
        @(posedge clk); #1;
        check_eq("t2_alu_A",   32'(alu_A), 32'hA);
        check_eq("t2_alu_B",   32'(alu_B), 7);
        check_eq("t2_alu_sel", 32'(alu_sel), 3);
        wait_drain();
        check_eq("t2_acc", 32'(acc), 1);

        // backpressure: FIFO fills, extra command refused
        res_ready = 1'b0;
        n_acc = 0;
        for (int i = 0; i < 6; i++) begin
            push_cmd(t_op[i], t_a[i], t_b[i], t_ua[i], 4, ok);
            if (ok) n_acc++;
        end
        check_eq("t3_accepted", n_acc, 5);
        check_eq("t3_count",    32'(fifo_count), 4);
        check_eq("t3_ready",    32'(cmd_ready), 0);
        base = n_results;
        res_ready = 1'b1;
        wait_drain();
        check_eq("t3_results",  n_results - base, 5);
        check_eq("t3_count_e",  32'(fifo_count), 0);
        check_eq("t3_ready_e",  32'(cmd_ready), 1);

        // illegal op
        push_ok(4'd13, 4'd5, 4'd5, 1'b0);
        @(posedge clk); #1;
        check_eq("t4_alu_sel", 32'(alu_sel), 0);
        check_eq("t4_alu_A",   32'(alu_A), 0);
        check_eq("t4_alu_B",   32'(alu_B), 0);
        wait_drain();

        // reset while holding a result with three commands queued
        res_ready = 1'b0;
        push_ok(4'd1, 4'd1, 4'd2, 1'b0);
        push_ok(4'd2, 4'd3, 4'd3, 1'b0);
        push_ok(4'd0, 4'd4, 4'd4, 1'b0);
        push_ok(4'd5, 4'd5, 4'd5, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("t5_pre_rv",    32'(res_valid), 1);
        check_eq("t5_pre_count", 32'(fifo_count), 3);
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_rv",    32'(res_valid), 0);
        check_eq("t5_count", 32'(fifo_count), 0);
        check_eq("t5_acc",   32'(acc), 0);
        check_eq("t5_ready", 32'(cmd_ready), 0);
        sb_q.delete();
        m_acc = '0;
        @(posedge clk); #1;
        check_eq("t5_ready_hold", 32'(cmd_ready), 0);
        rst = 1'b0;
        res_ready = 1'b1;
        @(posedge clk); #1;
        check_eq("t5_ready_rel", 32'(cmd_ready), 1);
        run_basic("t5");
        wait_drain();

        // accumulator clear: capture wins in ISSUE, clear works in IDLE
        push_ok(4'd0, 4'd3, 4'd2, 1'b0);
        @(posedge clk); #1;
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        check_eq("t6_acc_capture", 32'(acc), 5);
        check_eq("t6_rv",          32'(res_valid), 1);
        wait_drain();
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        m_acc = '0;
        check_eq("t6_acc_idle_clr", 32'(acc), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
